btn_debouncer: RTL and testbench

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

---
 rtl/btn_debouncer.sv | 141 ++++++++++++++
 tb/tb_btn_debouncer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
// Multi-channel push-button debouncer sampled on divided_clk rising edges, with press pulses and key encoding.
// Optional auto-repeat of held buttons is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_debouncer_lane #(
  parameter int STABLE_TICKS = 3,
  parameter int REPEAT_TICKS = 10
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam logic [3:0] CNT_MAX = 4'(STABLE_TICKS - 1);

  if (STABLE_TICKS < 1 || STABLE_TICKS > 15 || REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_bad_cfg
    $error("btn_debouncer: STABLE_TICKS or REPEAT_TICKS out of range");
  end

  logic       s1_q, s2_q;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       flip;

  // A tick that agrees with the current level restarts qualification.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    flip    = 1'b0;
    if (tick_i) begin
      if (s2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        level_d = ~level_q;
        flip    = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [7:0] RPT_MAX = 8'(REPEAT_TICKS - 1);
  logic [7:0] rpt_q, rpt_d;
  logic       rpt_fire;

  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    if (!level_q || flip) begin
      rpt_d = '0;
    end else if (tick_i) begin
      if (rpt_q == RPT_MAX) begin
        rpt_d    = '0;
        rpt_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end

  assign press_d = (flip & ~level_q) | rpt_fire;
`else
  assign press_d = flip & ~level_q;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
endmodule

module btn_debouncer #(
  parameter int NUM_BTN      = 4,
  parameter int STABLE_TICKS = 3,
  parameter int REPEAT_TICKS = 10
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               divided_clk,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [3:0]         key_code,
  output logic               key_valid
);
  logic div_q;
  logic tick;

  // div_q resets high so a divided_clk already high at reset release is not a tick.
  always_ff @(posedge clk_in) begin
    if (rst) div_q <= 1'b1;
    else     div_q <= divided_clk;
  end

  assign tick = divided_clk & ~div_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    btn_debouncer_lane #(
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_lane (
      .clk_in (clk_in),
      .rst    (rst),
      .tick_i (tick),
      .btn_i  (btn_in[i]),
      .level_o(btn_level[i]),
      .press_o(btn_press[i])
    );
  end

  always_comb begin
    key_code = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (btn_press[i]) key_code = 4'(i);
    end
  end

  assign key_valid = |btn_press;
endmodule

// File: tb/tb_btn_debouncer.sv
// Self-checking bench for btn_debouncer: directed scenarios plus random bouncing,
// compared every cycle against a tick-counting reference model.
module tb_btn_debouncer;
  localparam int NB = 4;
  localparam int ST = 3;
  localparam int RT = 4;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          divided_clk = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level, btn_press;
  logic [3:0]    key_code;
  logic          key_valid;

  btn_debouncer #(.NUM_BTN(NB), .STABLE_TICKS(ST), .REPEAT_TICKS(RT)) dut (
    .clk_in(clk_in), .rst(rst), .divided_clk(divided_clk), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // Reference: each channel remembers its accepted level, how many ticks in a row
  // disagreed with it, and how many ticks it has been held since the last pulse.
  int m_lvl[NB], m_run[NB], m_held[NB], m_press[NB], m_s1[NB], m_s2[NB];
  int m_divp = 1;
  int ph = 0;
  bit div_run = 1'b1, div_hold = 1'b0;
  int npress[NB];
  int last_code = -1;
  bit both23 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int tick;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_lvl[i] = 0; m_run[i] = 0; m_held[i] = 0; m_press[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
      m_divp = 1;
    end else begin
      tick = (divided_clk && m_divp == 0) ? 1 : 0;
      for (int i = 0; i < NB; i++) begin
        int was = m_lvl[i];
        int flipped = 0;
        m_press[i] = 0;
        if (tick == 1) begin
          m_run[i] = (m_s2[i] != was) ? m_run[i] + 1 : 0;
          if (m_run[i] == ST) begin
            m_run[i] = 0;
            m_lvl[i] = 1 - was;
            flipped = 1;
          end
        end
`ifdef BTN_AUTO_REPEAT_EN
        if (was == 0 || flipped == 1) m_held[i] = 0;
        else if (tick == 1) begin
          m_held[i] = m_held[i] + 1;
          if (m_held[i] == RT) begin
            m_held[i] = 0;
            m_press[i] = 1;
          end
        end
`endif
        if (flipped == 1 && m_lvl[i] == 1) m_press[i] = 1;
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(btn_in[i]);
      end
      m_divp = int'(divided_clk);
    end
  endtask

  task automatic cyc();
    logic [NB-1:0] el, ep;
    logic [3:0] ec;
    @(posedge clk_in);
    model_step();
    #1;
    el = '0; ep = '0; ec = '0;
    for (int i = 0; i < NB; i++) begin
      el[i] = (m_lvl[i] != 0);
      ep[i] = (m_press[i] != 0);
    end
    for (int i = NB - 1; i >= 0; i--) if (ep[i]) ec = 4'(i);
    chk("level", 32'(btn_level), 32'(el));
    chk("press", 32'(btn_press), 32'(ep));
    chk("key_code", 32'(key_code), 32'(ec));
    chk("key_valid", 32'(key_valid), 32'(ep != '0));
    for (int i = 0; i < NB; i++) npress[i] += int'(btn_press[i]);
    if (key_valid) last_code = int'(key_code);
    if (btn_press[3:2] == 2'b11) both23 = 1'b1;
    ph = (ph + 1) % 8;
    divided_clk = div_run ? (ph < 4) : div_hold;
  endtask

  task automatic advance(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) npress[i] = 0;
    last_code = -1;
    both23 = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    advance(n);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_keyv", 32'(key_valid), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    do_reset(3);
    advance(16);

    // Single clean press on channel 0
    clear_counts();
    btn_in[0] = 1'b1;
    advance(40);
    chk("p0_count", 32'(npress[0]), 32'd1);
    chk("p0_level", 32'(btn_level[0]), 32'd1);
    chk("p0_code", 32'(last_code), 32'd0);

    // Bouncing channel 1: 1,0,1 on successive ticks then steady
    btn_in = '0;
    do_reset(2);
    advance(16);
    clear_counts();
    btn_in[1] = 1'b1; advance(8);
    btn_in[1] = 1'b0; advance(8);
    chk("bounce_nopulse", 32'(npress[1]), 32'd0);
    btn_in[1] = 1'b1; advance(40);
    chk("bounce_count", 32'(npress[1]), 32'd1);
    chk("bounce_code", 32'(last_code), 32'd1);

    // Channels 2 and 3 together
    btn_in = '0;
    do_reset(2);
    advance(16);
    clear_counts();
    btn_in[3:2] = 2'b11;
    advance(40);
    chk("dual_2", 32'(npress[2]), 32'd1);
    chk("dual_3", 32'(npress[3]), 32'd1);
    chk("dual_same", 32'(both23), 32'd1);
    chk("dual_code", 32'(last_code), 32'd2);

    // Reset while held, divided_clk high across release
    btn_in = '0;
    do_reset(2);
    advance(16);
    btn_in[0] = 1'b1;
    advance(40);
    chk("held_level", 32'(btn_level[0]), 32'd1);
    div_run = 1'b0; div_hold = 1'b1; divided_clk = 1'b1;
    advance(1);
    do_reset(1);
    clear_counts();
    advance(3);
    chk("post_rst_level", 32'(btn_level[0]), 32'd0);
    div_run = 1'b1;
    advance(37);
    chk("post_rst_count", 32'(npress[0]), 32'd1);
    chk("post_rst_lvl1", 32'(btn_level[0]), 32'd1);

    // Long hold then release
    btn_in = '0;
    do_reset(2);
    advance(16);
    clear_counts();
    btn_in[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      cyc();
      if (btn_press[0]) seen = 1'b1;
    end
    chk("hold_accept_seen", 32'(seen), 32'd1);
    advance(160);
    btn_in[0] = 1'b0;
    advance(60);
`ifdef BTN_AUTO_REPEAT_EN
    chk("hold_count", 32'(npress[0]), 32'd6);
`else
    chk("hold_count", 32'(npress[0]), 32'd1);
`endif
    chk("release_level", 32'(btn_level[0]), 32'd0);

    // Random bouncing with occasional frozen divided_clk
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 19) == 0) btn_in[i] = ~btn_in[i];
      if ($urandom_range(0, 149) == 0) begin
        div_run = ~div_run;
        div_hold = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      else rst = 1'b0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
